// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, preload table and address checking for the data-memory responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int WORD_SHIFT = 2;
    localparam int INIT_N = 21;
    localparam logic [0:INIT_N-1][31:0] INIT_TABLE = '{
        32'd0, 32'd19, 32'd36, 32'd51, 32'd64, 32'd75, 32'd84, 32'd91, 32'd96, 32'd99, 32'd100,
        32'd99, 32'd96, 32'd91, 32'd84, 32'd75, 32'd64, 32'd51, 32'd36, 32'd19, 32'd0
    };
    function automatic logic addr_is_err(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ((addr >> WORD_SHIFT) >= 32'(depth));
    endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response channels between the MEM stage and the responder.
interface dmem_if #(parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: word storage with one synchronous write and one registered read port, preloaded, never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 40,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    function automatic logic [DEPTH-1:0][DATA_W-1:0] init_image();
        logic [DEPTH-1:0][DATA_W-1:0] img = '0;
        for (int i = 0; i < DEPTH && i < INIT_N; i++) img[i] = DATA_W'(INIT_TABLE[i]);
        return img;
    endfunction

    logic [DEPTH-1:0][DATA_W-1:0] mem = init_image();

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory slave with fixed response latency and alignment/range checking.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 40,
    parameter int LATENCY = 2,
    parameter int DATA_W  = 32
) (
    input logic clk,
    input logic reset,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic              cap_write;
    logic              cap_err;
    logic [AW-1:0]     cap_idx;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rd_q;
    logic              req_err;
    logic [AW-1:0]     req_idx;
    logic              commit;
    logic              we;
    logic [AW-1:0]     raddr;

    assign req_err = addr_is_err(bus.req_addr, DEPTH);
    assign req_idx = req_err ? '0 : AW'(bus.req_addr >> WORD_SHIFT);
    assign commit  = (state == WAIT) && (cnt == 4'd0);
    // reset must veto an uncommitted store even on its commit edge
    assign we      = commit && cap_write && !cap_err && !reset;
    // read the incoming address while idle so the word is ready even at LATENCY=1
    assign raddr   = (state == IDLE) ? req_idx : cap_idx;

    dmem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
        .clk  (clk),
        .we   (we),
        .waddr(cap_idx),
        .wdata(cap_wdata),
        .raddr(raddr),
        .rdata(rd_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_write      <= 1'b0;
            cap_err        <= 1'b0;
            cap_idx        <= '0;
            cap_wdata      <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    cap_write     <= bus.req_write;
                    cap_err       <= req_err;
                    cap_idx       <= req_idx;
                    cap_wdata     <= bus.req_wdata;
                    cnt           <= 4'(LATENCY - 1);
                    bus.req_ready <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: if (cnt == 4'd0) begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= (cap_write || cap_err) ? '0 : rd_q;
                    bus.resp_err   <= cap_err;
                    state          <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store, error, backpressure and mid-request reset checks.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    dmem_if #(.DATA_W(32)) bus ();

    dmem_responder #(.DEPTH(40), .LATENCY(2), .DATA_W(32)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic transact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_d, input logic exp_e);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        tick();
        bus.req_valid = 1'b0;
        check({tag, "_ready_low"}, 32'(bus.req_ready), 32'd0);
        while (!bus.resp_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd2);
        check({tag, "_rdata"}, bus.resp_rdata, exp_d);
        check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_e));
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check({tag, "_done"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b0;
        tick();

        transact("ld28", 1'b0, 32'h28, 32'h0, 32'd100, 1'b0);
        transact("st08", 1'b1, 32'h08, 32'h5A, 32'd0, 1'b0);
        transact("ld08", 1'b0, 32'h08, 32'h0, 32'h5A, 1'b0);
        transact("st06", 1'b1, 32'h06, 32'h77, 32'd0, 1'b1);
        transact("ld04", 1'b0, 32'h04, 32'h0, 32'd19, 1'b0);
        transact("ldA0", 1'b0, 32'hA0, 32'h0, 32'd0, 1'b1);
        transact("ld9C", 1'b0, 32'h9C, 32'h0, 32'd0, 1'b0);
        transact("ld428", 1'b0, 32'h428, 32'h0, 32'd0, 1'b1);

        // backpressure: hold a completed response while a new request waits
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h14;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("bp_valid_up", 32'(bus.resp_valid), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h18;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", {bus.resp_valid, bus.resp_err, bus.req_ready, 29'd0} | bus.resp_rdata,
                  {1'b1, 1'b0, 1'b0, 29'd0} | 32'd75);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("bp_hs_valid", 32'(bus.resp_valid), 32'd0);
        check("bp_hs_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check("bp_accept", 32'(bus.req_ready), 32'd0);
        tick();
        check("bp_wait", 32'(bus.resp_valid), 32'd0);
        tick();
        check("bp2_valid", 32'(bus.resp_valid), 32'd1);
        check("bp2_rdata", bus.resp_rdata, 32'd84);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;

        // reset while a store is waiting to commit
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h1234;
        tick();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_mid_novalid", 32'(bus.resp_valid), 32'd0);
        end
        transact("ld10", 1'b0, 32'h10, 32'h0, 32'd64, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
